// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
//   Encodings shared by the instruction fetch unit, the program counter and
//   the control unit.
//   - PC_*  : program counter enable encodings carried on pc_en
//   - ST_*  : fetch FSM state constants
//   - redirect_to_pc_en() : maps the 2-bit redirect request of a handed-off
//     instruction onto a pc_en encoding
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

    // Program counter enable encodings
    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_INC    = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_BRANCH = 2'b11;

    // Fetch FSM states
    localparam logic [1:0] ST_FETCH  = 2'b00;
    localparam logic [1:0] ST_HOLD   = 2'b01;
    localparam logic [1:0] ST_ERR    = 2'b10;

    // 10 (jump) and 11 (branch) pass through; 00 and 01 both mean sequential.
    function automatic logic [1:0] redirect_to_pc_en(input logic [1:0] redirect);
        return redirect[1] ? redirect : PC_INC;
    endfunction

endpackage : instr_fetch_pkg

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Fetches one instruction word per request from instruction memory into an
//   instruction register, holds it until decode accepts it and execute is not
//   stalled, then tells the program counter how to advance.
//
//   Optional feature (macro FETCH_TIMEOUT_EN): a fetch that waits TIMEOUT
//   cycles without mem_ack drops into a sticky error state until reset.
//   With the macro undefined, fetch waits indefinitely and fetch_err is 0.
//
//   Parameters
//     ADDR_W   PC / memory address width
//     DATA_W   instruction word width
//     TIMEOUT  fetch cycles without ack before error (FETCH_TIMEOUT_EN only)
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-low reset
//     pc         in   current PC from the program counter register
//     mem_req    out  instruction memory read request
//     mem_addr   out  read address (follows pc combinationally)
//     mem_ack    in   read data valid
//     mem_rdata  in   read data
//     ir         out  instruction register
//     ir_valid   out  ir holds an unconsumed instruction
//     ir_ready   in   decode accepts ir this cycle
//     stall      in   execute busy, blocks hand-off
//     redirect   in   PC action for the handed-off instruction
//     pc_en      out  program counter enable (hold / +1 / jump / branch)
//     fetch_err  out  sticky fetch timeout flag
// ---------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              stall,
    input  logic [1:0]        redirect,
    output logic [1:0]        pc_en,
    output logic              fetch_err
);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              handoff;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_hit;

    // Last ack-less FETCH cycle before the budget runs out.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == ST_FETCH && !mem_ack && !timeout_hit) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_err = (state_q == ST_ERR);
`else
    assign fetch_err = 1'b0;
`endif

    // Outputs are decoded straight from state so the PC change at the
    // hand-off edge is visible on mem_addr in the very next cycle.
    assign mem_req  = (state_q == ST_FETCH);
    assign mem_addr = pc;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
    assign handoff  = (state_q == ST_HOLD) && ir_ready && !stall;
    assign pc_en    = handoff ? redirect_to_pc_en(redirect) : PC_HOLD;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis would infer a latch.
        state_d    = state_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;

        case (state_q)
            ST_FETCH: begin
                if (mem_ack) begin
                    ir_d       = mem_rdata;
                    ir_valid_d = 1'b1;
                    state_d    = ST_HOLD;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = ST_ERR;
                end
`endif
            end
            ST_HOLD: begin
                // Acks arriving here are stray and deliberately ignored.
                if (handoff) begin
                    ir_valid_d = 1'b0;
                    state_d    = ST_FETCH;
                end
            end
            ST_ERR: begin
                ir_valid_d = 1'b0;
            end
            default: begin
                ir_valid_d = 1'b0;
                state_d    = ST_FETCH;
            end
        endcase
    end

    // NOTE: ir is reset as well as ir_valid so that a freshly reset core
    // shows a defined all-zero instruction rather than stale data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_FETCH;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so all registers update
            // together from the values computed in the previous cycle.
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Self-checking bench for instr_fetch. A small memory model answers fetch
//   requests; every word it returns is pushed to a scoreboard and popped when
//   the DUT hands the instruction off. A program counter model follows pc_en.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam logic [AW-1:0] JUMP_T = 16'h0100;
    localparam logic [AW-1:0] BR_T   = 16'h0200;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] pc_r = '0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] ir;
    logic          ir_valid;
    logic          ir_ready = 1'b0;
    logic          stall = 1'b0;
    logic [1:0]    redirect = 2'b00;
    logic [1:0]    pc_en;
    logic          fetch_err;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc_r),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .stall     (stall),
        .redirect  (redirect),
        .pc_en     (pc_en),
        .fetch_err (fetch_err)
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    logic [1:0]    last_pc_en = 2'b00;
    logic [DW-1:0] sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 16'h0000) return 16'h1234;
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // PC the program counter register will hold after applying last_pc_en.
    function automatic logic [AW-1:0] next_pc();
        case (last_pc_en)
            2'b01:   return pc_r + 16'd1;
            2'b10:   return JUMP_T;
            2'b11:   return BR_T;
            default: return pc_r;
        endcase
    endfunction

    function automatic logic [1:0] exp_en(input logic [1:0] rd);
        case (rd)
            2'b10:   return 2'b10;
            2'b11:   return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    // One clock cycle: update PC model, drive inputs, settle, sample pc_en.
    task automatic step(input logic ack, input logic [DW-1:0] rd_data,
                        input logic rdy, input logic stl, input logic [1:0] rdr);
        @(negedge clk);
        pc_r      = next_pc();
        mem_ack   = ack;
        mem_rdata = rd_data;
        ir_ready  = rdy;
        stall     = stl;
        redirect  = rdr;
        #1;
        last_pc_en = pc_en;
        cyc++;
    endtask

    task automatic txn(input int lat, input int hold, input bit stall_only, input logic [1:0] rd);
        logic [DW-1:0] d;
        for (int i = 0; i < lat; i++) begin
            step(1'b0, 16'hDEAD, 1'b1, 1'b0, 2'b10);
            check("wait_req", mem_req, 1);
            check("wait_addr", mem_addr, pc_r);
            check("wait_pc_en", pc_en, 0);
            check("wait_ir_valid", ir_valid, 0);
        end
        d = mem_word(next_pc());
        step(1'b1, d, 1'b1, 1'b0, 2'b11);
        check("ack_req", mem_req, 1);
        check("ack_addr", mem_addr, pc_r);
        check("ack_pc_en", pc_en, 0);
        sb.push_back(d);
        for (int i = 0; i < hold; i++) begin
            if (stall_only) step(1'b1, ~d, 1'b1, 1'b1, rd);
            else            step(1'b1, ~d, (i % 2) == 0, (i % 2) == 0, rd);
            check("hold_valid", ir_valid, 1);
            check("hold_req", mem_req, 0);
            check("hold_pc_en", pc_en, 0);
            check("hold_ir", ir, sb[0]);
        end
        step(1'b1, ~d, 1'b1, 1'b0, rd);
        check("handoff_valid", ir_valid, 1);
        check("handoff_req", mem_req, 0);
        check("handoff_pc_en", pc_en, exp_en(rd));
        if (sb.size() == 0) check("handoff_sb_nonempty", 0, 1);
        else                check("handoff_ir", ir, sb.pop_front());
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_ir_valid", ir_valid, 0);
        check("rst_fetch_err", fetch_err, 0);
        check("rst_ir", ir, 0);
        check("rst_req", mem_req, 1);
        check("rst_pc_en", pc_en, 0);
        sb.delete();
        last_pc_en = 2'b00;
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        int c0;
        logic [1:0] rd;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ir_valid", ir_valid, 0);
        check("reset_req", mem_req, 1);
        check("reset_addr", mem_addr, 16'h0000);
        check("reset_pc_en", pc_en, 0);
        check("reset_fetch_err", fetch_err, 0);
        check("reset_ir", ir, 0);
        #1 rst = 1'b1;

        // First fetch at pc 0, ack in the first cycle, then +1 to 0x0001
        txn(0, 0, 1'b0, 2'b00);
        step(1'b0, 16'h0, 1'b1, 1'b0, 2'b00);
        check("after_first_addr", mem_addr, 16'h0001);
        check("after_first_valid", ir_valid, 0);

        // Delayed ack and stall with pending jump
        txn(5, 0, 1'b0, 2'b00);
        txn(1, 3, 1'b1, 2'b10);
        check("jump_target_addr", next_pc(), JUMP_T);
        txn(2, 2, 1'b0, 2'b11);
        txn(0, 0, 1'b0, 2'b01);
        txn(1, 1, 1'b0, 2'b00);

        // Back-to-back issue rate: one instruction every two cycles
        c0 = cyc;
        repeat (4) txn(0, 0, 1'b0, 2'b00);
        check("issue_rate_cycles", cyc - c0, 8);

        // Randomised mix
        for (int k = 0; k < 8; k++) begin
            rd = 2'($urandom_range(0, 3));
            txn(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'b0, rd);
        end

        // Reset while waiting for ack, then a fresh request for current pc
        step(1'b0, 16'h0, 1'b1, 1'b0, 2'b00);
        step(1'b0, 16'h0, 1'b1, 1'b0, 2'b00);
        pulse_reset();
        txn(0, 1, 1'b0, 2'b00);

        // Reset while holding an instruction
        step(1'b1, mem_word(next_pc()), 1'b1, 1'b1, 2'b00);
        step(1'b0, 16'h0, 1'b1, 1'b1, 2'b00);
        check("pre_rst_hold_valid", ir_valid, 1);
        pulse_reset();
        txn(1, 0, 1'b0, 2'b11);

`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 16'h0, 1'b1, 1'b0, 2'b00);
            check("to_wait_req", mem_req, 1);
            check("to_wait_err", fetch_err, 0);
        end
        step(1'b1, 16'hBEEF, 1'b1, 1'b0, 2'b10);
        check("to_err", fetch_err, 1);
        check("to_req", mem_req, 0);
        check("to_pc_en", pc_en, 0);
        check("to_valid", ir_valid, 0);
        step(1'b1, 16'hBEEF, 1'b1, 1'b0, 2'b10);
        check("to_sticky", fetch_err, 1);
        pulse_reset();
        txn(0, 0, 1'b0, 2'b00);
`endif

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_instr_fetch
